// File: rtl/loeffler_seq_pkg.sv
// loeffler_seq_pkg: FSM encoding and core state codes shared by the Loeffler DCT sequencer.
package loeffler_seq_pkg;
    localparam int N_PTS = 8;
    localparam logic [1:0] CS_HOLD = 2'b00;
    localparam logic [1:0] CS_LOAD = 2'b01;
    localparam logic [1:0] CS_CALC = 2'b10;
    localparam logic [1:0] CS_OUT  = 2'b11;
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_CALC, ST_READ, ST_DRAIN} seq_state_t;
endpackage

// File: rtl/loeffler_seq_buf.sv
// loeffler_seq_buf: N_PTS x CW coefficient register file, one write port, async read, no data reset.
module loeffler_seq_buf
    import loeffler_seq_pkg::*;
#(
    parameter int CW = 12
)(
    input  logic          clk,
    input  logic          we_i,
    input  logic [2:0]    wa_i,
    input  logic [CW-1:0] wd_i,
    input  logic [2:0]    ra_i,
    output logic [CW-1:0] rd_o
);
    logic [CW-1:0] mem_q [N_PTS];
    always_ff @(posedge clk) begin
        if (we_i) mem_q[wa_i] <= wd_i;
    end
    assign rd_o = mem_q[ra_i];
endmodule

// File: rtl/loeffler_seq.sv
// loeffler_seq: sequences LOAD/CALC/OUT for the 8-point Loeffler DCT core and drains its coefficients.
// Define LOEFFLER_SEQ_STATS_EN to add the blk_cnt and ovf_err status ports.
module loeffler_seq
    import loeffler_seq_pkg::*;
#(
    parameter int DW       = 8,
    parameter int CW       = 12,
    parameter int CALC_CYC = 4,
    parameter int OUT_LAT  = 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic [1:0]    core_state,
    output logic [DW-1:0] core_in,
    input  logic [CW-1:0] core_out,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [CW-1:0] m_data,
    output logic          m_last,
    output logic          busy
`ifdef LOEFFLER_SEQ_STATS_EN
    ,
    output logic [15:0]   blk_cnt,
    output logic          ovf_err
`endif
);
    localparam logic [2:0] LAST      = 3'(N_PTS - 1);
    localparam logic [2:0] CALC_LAST = 3'(CALC_CYC - 1);
    seq_state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d, wr_q, wr_d;
    logic iss_q, iss_d;
    logic [1:0] cs_q, cs_d;
    logic [DW-1:0] in_q, in_d;
    logic [OUT_LAT-1:0] dly_q;
    logic acc, wr_en;

    assign s_ready    = state_q == ST_IDLE || state_q == ST_LOAD;
    assign acc        = s_valid && s_ready;
    // Write strobe trails each OUT cycle by the core's output latency.
    assign wr_en      = dly_q[OUT_LAT-1];
    assign m_valid    = state_q == ST_DRAIN;
    assign m_last     = m_valid && cnt_q == LAST;
    assign busy       = state_q != ST_IDLE;
    assign core_state = cs_q;
    assign core_in    = in_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        iss_d   = iss_q;
        cs_d    = CS_HOLD;
        in_d    = in_q;
        unique case (state_q)
            ST_IDLE: if (acc) begin
                in_d    = s_data;
                cs_d    = CS_LOAD;
                cnt_d   = 3'd1;
                state_d = ST_LOAD;
            end
            ST_LOAD: if (acc) begin
                in_d    = s_data;
                cs_d    = CS_LOAD;
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == LAST) begin
                    cnt_d   = 3'd0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                cs_d  = CS_CALC;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == CALC_LAST) begin
                    cnt_d   = 3'd0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                // iss_q marks all N OUT cycles issued; the state then waits for the trailing writes.
                if (!iss_q) begin
                    cs_d  = CS_OUT;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == LAST) begin
                        cnt_d = 3'd0;
                        iss_d = 1'b1;
                    end
                end
                if (wr_en) begin
                    wr_d = wr_q + 3'd1;
                    if (wr_q == LAST) begin
                        wr_d    = 3'd0;
                        iss_d   = 1'b0;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: if (m_ready) begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST) begin
                    cnt_d   = 3'd0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= '0;
            iss_q   <= 1'b0;
            cs_q    <= CS_HOLD;
            in_q    <= '0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            iss_q   <= iss_d;
            cs_q    <= cs_d;
            in_q    <= in_d;
            dly_q   <= OUT_LAT'({dly_q, cs_q == CS_OUT});
        end
    end

    loeffler_seq_buf #(.CW(CW)) u_buf (
        .clk  (clk),
        .we_i (wr_en),
        .wa_i (wr_q),
        .wd_i (core_out),
        .ra_i (cnt_q),
        .rd_o (m_data)
    );

`ifdef LOEFFLER_SEQ_STATS_EN
    logic [15:0] blk_q;
    logic ovf_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (m_valid && m_ready && m_last) blk_q <= blk_q + 16'd1;
            if (s_valid && !s_ready && busy) ovf_q <= 1'b1;
        end
    end
    assign blk_cnt = blk_q;
    assign ovf_err = ovf_q;
`endif
endmodule
